// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue-side sequencer:
// op codes for both modes, mode values, flag bit positions, FSM states.
package alu_pkg;

  // Mode select
  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;

  // Arithmetic/logic op codes (mode 0)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  // Single-bit shift/rotate op codes (mode 1)
  localparam logic [2:0] OP_LSR = 3'd0;
  localparam logic [2:0] OP_LSL = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ASL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  localparam logic [2:0] OP_ROL = 3'd5;

  // Codes 6 and 7 are undefined in both modes
  localparam logic [2:0] OP_FIRST_ILLEGAL = 3'd6;

  // Bit positions inside the 4-bit {N,Z,CO,V} flag vector
  localparam int unsigned FLAG_N  = 3;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_CO = 1;
  localparam int unsigned FLAG_V  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage : alu_pkg

// File: rtl/alu_op_sequencer.sv
// Issue-side controller for the combinational ALU. Latches one request,
// drives the ALU inputs from registers, and builds a registered response.
// Multi-bit shifts/rotates are done by re-feeding the ALU's single-bit
// shift result for 'cnt' cycles.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W  = 17,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  // request side
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_mode,
  input  logic [2:0]    req_op,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  input  logic [CW-1:0] req_cnt,
  // ALU input side
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic          alu_mode,
  output logic [2:0]    alu_op,
  // ALU output side
  input  logic [W-1:0]  alu_out,
  input  logic          alu_co,
  input  logic          alu_n,
  input  logic          alu_v,
  input  logic          alu_z,
  // response side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_result,
  output logic [3:0]    rsp_flags,
  output logic          rsp_err,
  output logic          busy
);

  seq_state_e    state_q;
  logic [W-1:0]  work_q;
  logic [W-1:0]  b_q;
  logic          mode_q;
  logic [2:0]    op_q;
  logic [CW-1:0] rem_q;
  logic [W-1:0]  result_q;
  logic [3:0]    flags_q;
  logic          err_q;

  // Shift results carry no ALU flags; derive N/Z from the value itself.
  function automatic logic [3:0] shift_flags(input logic [W-1:0] r);
    logic [3:0] f;
    f          = 4'b0000;
    f[FLAG_N]  = r[W-1];
    f[FLAG_Z]  = (r == '0);
    return f;
  endfunction

  // Arithmetic flags exactly as the ALU reports them, packed {N,Z,CO,V}.
  logic [3:0] alu_flags_d;
  always_comb begin
    alu_flags_d          = 4'b0000;
    alu_flags_d[FLAG_N]  = alu_n;
    alu_flags_d[FLAG_Z]  = alu_z;
    alu_flags_d[FLAG_CO] = alu_co;
    alu_flags_d[FLAG_V]  = alu_v;
  end

  // Sequencer FSM together with all datapath and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      op_q     <= 3'd0;
      rem_q    <= '0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            work_q <= req_a;
            b_q    <= req_b;
            mode_q <= req_mode;
            op_q   <= req_op;
            rem_q  <= req_cnt;
            err_q  <= 1'b0;
            if (req_op >= OP_FIRST_ILLEGAL) begin
              result_q <= '0;
              flags_q  <= 4'b0000;
              err_q    <= 1'b1;
              state_q  <= ST_DONE;
            end else if (req_mode == MODE_ARITH) begin
              state_q <= ST_EXEC;
            end else if (req_cnt == '0) begin
              // zero-count shift: answer is the operand itself
              result_q <= req_a;
              flags_q  <= shift_flags(req_a);
              state_q  <= ST_DONE;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_EXEC: begin
          result_q <= alu_out;
          flags_q  <= alu_flags_d;
          state_q  <= ST_DONE;
        end
        ST_SHIFT: begin
          work_q <= alu_out;
          rem_q  <= rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            result_q <= alu_out;
            flags_q  <= shift_flags(alu_out);
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

  assign alu_a    = work_q;
  assign alu_b    = b_q;
  assign alu_mode = mode_q;
  assign alu_op   = op_q;

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU beside it.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned W  = 17;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_mode;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [CW-1:0] req_cnt;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          alu_mode;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_out;
  logic          alu_co, alu_n, alu_v, alu_z;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic          rsp_err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_op(alu_op),
    .alu_out(alu_out), .alu_co(alu_co), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU: carry is "no borrow" on SUB, V is signed overflow.
  always_comb begin
    logic [W:0] sum;
    sum     = '0;
    alu_out = '0;
    alu_co  = 1'b0;
    alu_v   = 1'b0;
    if (alu_mode == MODE_ARITH) begin
      case (alu_op)
        OP_ADD: begin
          sum     = {1'b0, alu_a} + {1'b0, alu_b};
          alu_out = sum[W-1:0];
          alu_co  = sum[W];
          alu_v   = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
        end
        OP_SUB: begin
          sum     = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1);
          alu_out = sum[W-1:0];
          alu_co  = sum[W];
          alu_v   = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
        end
        OP_AND:  alu_out = alu_a & alu_b;
        OP_OR:   alu_out = alu_a | alu_b;
        OP_XOR:  alu_out = alu_a ^ alu_b;
        default: alu_out = '0;
      endcase
    end else begin
      case (alu_op)
        OP_LSR:  alu_out = alu_a >> 1;
        OP_LSL:  alu_out = alu_a << 1;
        OP_ASR:  alu_out = {alu_a[W-1], alu_a[W-1:1]};
        OP_ASL:  alu_out = alu_a << 1;
        OP_ROR:  alu_out = {alu_a[0], alu_a[W-1:1]};
        OP_ROL:  alu_out = {alu_a[W-2:0], alu_a[W-1]};
        default: alu_out = '0;
      endcase
    end
    alu_n = alu_out[W-1];
    alu_z = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; it is accepted at the next edge.
  task automatic send_req(input string tag, input logic m, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [CW-1:0] cnt);
    int guard = 0;
    while (!req_ready && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_mode  = m;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cnt   = cnt;
    tick();
    req_valid = 1'b0;
  endtask

  // Latency counted in edges after accept at which rsp_valid is first seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic m, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [CW-1:0] cnt, input logic [W-1:0] exp_res,
                       input logic [3:0] exp_flags, input logic exp_err, input int exp_lat);
    int lat;
    send_req(tag, m, op, a, b, cnt);
    wait_rsp(lat);
    check({tag, "_lat"},    32'(lat),        32'(exp_lat));
    check({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_flags"},  32'(rsp_flags),  32'(exp_flags));
    check({tag, "_err"},    32'(rsp_err),    32'(exp_err));
    $display("op %s: result=0x%05h flags=%04b err=%0d lat=%0d", tag, rsp_result, rsp_flags, rsp_err, lat);
    consume(tag);
  endtask

  initial begin
    logic [W-1:0] held_res;
    int lat;
    int seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_op    = 3'd0;
    req_a     = '0;
    req_b     = '0;
    req_cnt   = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outs", {alu_a, alu_b, alu_mode, alu_op, rsp_valid, rsp_err, busy}, 32'd0);
    check("rst_rsp", {11'd0, rsp_result, rsp_flags}, 32'd0);

    //     tag        mode op      a          b          cnt    result     NZCV     err lat
    do_op("add_ovf",  1'b0, OP_ADD, 17'h0FFFF, 17'h00001, 5'd0,  17'h10000, 4'b1001, 1'b0, 2);
    do_op("sub_neg",  1'b0, OP_SUB, 17'h00005, 17'h00007, 5'd0,  17'h1FFFE, 4'b1000, 1'b0, 2);
    do_op("sub_zero", 1'b0, OP_SUB, 17'h00007, 17'h00007, 5'd0,  17'h00000, 4'b0110, 1'b0, 2);
    do_op("and",      1'b0, OP_AND, 17'h1F0F0, 17'h0FF00, 5'd0,  17'h0F000, 4'b0000, 1'b0, 2);

    // LSL by 3: watch the work register walk through the ALU
    send_req("lsl3", 1'b1, OP_LSL, 17'h00001, 17'h1ABCD, 5'd3);
    check("lsl3_busy", 32'(busy), 32'd1);
    check("lsl3_alu_a0", 32'(alu_a), 32'h1);
    check("lsl3_alu_ctl", {28'd0, alu_mode, alu_op}, 32'({MODE_SHIFT, OP_LSL}));
    tick();
    check("lsl3_alu_a1", 32'(alu_a), 32'h2);
    tick();
    check("lsl3_alu_a2", 32'(alu_a), 32'h4);
    check("lsl3_notyet", 32'(rsp_valid), 32'd0);
    tick();
    check("lsl3_valid", 32'(rsp_valid), 32'd1);
    check("lsl3_result", 32'(rsp_result), 32'h8);
    check("lsl3_flags", 32'(rsp_flags), 32'h0);
    $display("op lsl3: result=0x%05h flags=%04b", rsp_result, rsp_flags);
    consume("lsl3");

    do_op("ror17",    1'b1, OP_ROR, 17'h00003, 17'h00000, 5'd17, 17'h00003, 4'b0000, 1'b0, 18);
    do_op("lsr20",    1'b1, OP_LSR, 17'h1FFFF, 17'h00000, 5'd20, 17'h00000, 4'b0100, 1'b0, 21);
    do_op("asr2",     1'b1, OP_ASR, 17'h10000, 17'h00000, 5'd2,  17'h1C000, 4'b1000, 1'b0, 3);
    do_op("cnt0",     1'b1, OP_LSL, 17'h10000, 17'h00000, 5'd0,  17'h10000, 4'b1000, 1'b0, 1);
    do_op("illegal6", 1'b0, 3'd6,   17'h12345, 17'h00001, 5'd0,  17'h00000, 4'b0000, 1'b1, 1);
    do_op("illegal7", 1'b1, 3'd7,   17'h12345, 17'h00001, 5'd4,  17'h00000, 4'b0000, 1'b1, 1);

    // Backpressure: response held, extra request ignored
    send_req("bp", 1'b0, OP_OR, 17'h00F00, 17'h000F0, 5'd0);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd2);
    held_res  = rsp_result;
    check("bp_result", 32'(held_res), 32'h00FF0);
    req_valid = 1'b1;
    req_mode  = 1'b0;
    req_op    = OP_ADD;
    req_a     = 17'h00001;
    req_b     = 17'h00001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_result", 32'(rsp_result), 32'(held_res));
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    $display("bp: held result=0x%05h for 5 cycles", rsp_result);
    consume("bp");
    do_op("after_bp", 1'b0, OP_XOR, 17'h1FFFF, 17'h0000F, 5'd0, 17'h1FFF0, 4'b1000, 1'b0, 2);

    // Reset during SHIFT with 4 iterations left
    send_req("rst_mid", 1'b1, OP_ROL, 17'h00001, 17'h00055, 5'd10);
    for (int i = 0; i < 6; i++) tick();
    check("rst_mid_alu_a", 32'(alu_a), 32'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_outs", {alu_a, alu_b, alu_mode, alu_op, rsp_valid, rsp_err, busy}, 32'd0);
    check("rst_mid_rsp", {11'd0, rsp_result, rsp_flags}, 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("rst_mid_no_rsp", 32'(seen), 32'd0);
    $display("rst_mid: dropped in-flight shift, responses seen=%0d", seen);

    do_op("post_rst", 1'b0, OP_ADD, 17'h00002, 17'h00003, 5'd0, 17'h00005, 4'b0000, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_op_sequencer
